// File: rtl/wb_ppfifo_2_mem_pkg.sv
// Shared state encoding, default buffer bases and helpers for wb_ppfifo_2_mem.
package wb_ppfifo_2_mem_pkg;

  typedef enum logic [2:0] {
    P2M_IDLE     = 3'd0,
    P2M_ACTIVATE = 3'd1,
    P2M_WRITE    = 3'd2,
    P2M_WAIT_ACK = 3'd3
  } p2m_state_e;

  localparam int DATA_W      = 32;
  localparam int FIFO_SIZE_W = 24;

  localparam logic [31:0] DEFAULT_MEM_0_BASE = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_MEM_1_BASE = 32'h0010_0000;

  // Buffers are word addressed, so the next target is simply base plus words written.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] count);
    return base + count;
  endfunction

endpackage

// File: rtl/wb_ppfifo_2_mem_buffer_ctrl.sv
// Bookkeeping for one destination buffer: latched base/size, words written, finished flag.
module p2m_buffer_ctrl
  import wb_ppfifo_2_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        arm_i,
  input  logic [31:0] base_i,
  input  logic [31:0] size_i,
  input  logic        inc_i,
  input  logic        finish_i,
  output logic [31:0] base_o,
  output logic [31:0] count_o,
  output logic        ready_o,
  output logic        last_o,
  output logic        finished_o,
  output logic        empty_o
);

  logic        armed_q, armed_d;
  logic [31:0] base_q, base_d;
  logic [31:0] size_q, size_d;
  logic [31:0] count_q, count_d;
  logic        finished_q, finished_d;

  always_comb begin
    armed_d    = armed_q;
    base_d     = base_q;
    size_d     = size_q;
    count_d    = count_q;
    finished_d = finished_q;
    // A zero-length arm request would never finish, so it is dropped.
    if (arm_i && (size_i != 32'd0)) begin
      armed_d    = 1'b1;
      base_d     = base_i;
      size_d     = size_i;
      count_d    = 32'd0;
      finished_d = 1'b0;
    end else begin
      if (inc_i)    count_d    = count_q + 32'd1;
      if (finish_i) finished_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q    <= 1'b0;
      base_q     <= 32'd0;
      size_q     <= 32'd0;
      count_q    <= 32'd0;
      finished_q <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      base_q     <= base_d;
      size_q     <= size_d;
      count_q    <= count_d;
      finished_q <= finished_d;
    end
  end

  assign base_o     = base_q;
  assign count_o    = count_q;
  assign ready_o    = armed_q & ~finished_q;
  assign last_o     = (count_q + 32'd1) == size_q;
  assign finished_o = finished_q;
  assign empty_o    = ~ready_o;

endmodule

// File: rtl/wb_ppfifo_2_mem.sv
// Drains ping-pong FIFO blocks into two alternating memory buffers over a Wishbone master.
// Define WB_PPFIFO_2_MEM_DEBUG_EN to expose internal status on the debug port.
module wb_ppfifo_2_mem
  import wb_ppfifo_2_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] debug,
  input  logic        i_enable,
  input  logic        i_flush,
  input  logic [31:0] i_memory_0_base,
  input  logic [31:0] i_memory_0_size,
  output logic [31:0] o_memory_0_count,
  input  logic        i_memory_0_ready,
  output logic        o_memory_0_finished,
  output logic        o_memory_0_empty,
  output logic [31:0] o_default_mem_0_base,
  input  logic [31:0] i_memory_1_base,
  input  logic [31:0] i_memory_1_size,
  output logic [31:0] o_memory_1_count,
  input  logic        i_memory_1_ready,
  output logic        o_memory_1_finished,
  output logic        o_memory_1_empty,
  output logic [31:0] o_default_mem_1_base,
  output logic        o_write_finished,
  output logic        o_mem_we,
  output logic        o_mem_stb,
  output logic        o_mem_cyc,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  input  logic [31:0] i_mem_dat,
  input  logic        i_mem_ack,
  input  logic        i_mem_int,
  input  logic        i_ppfifo_rdy,
  output logic        o_ppfifo_act,
  input  logic [23:0] i_ppfifo_size,
  output logic        o_ppfifo_stb,
  input  logic [31:0] i_ppfifo_data
);

  localparam logic [2:0] ST_IDLE     = P2M_IDLE;
  localparam logic [2:0] ST_ACTIVATE = P2M_ACTIVATE;
  localparam logic [2:0] ST_WRITE    = P2M_WRITE;
  localparam logic [2:0] ST_WAIT_ACK = P2M_WAIT_ACK;

  logic [2:0]  state_q, state_d;
  logic        active_q, active_d;
  logic        act_q, act_d;
  logic        bus_q, bus_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [23:0] blk_q, blk_d;
  logic        wr_fin_q, wr_fin_d;
  logic        flush_pend_q, flush_pend_d;

  logic [31:0] b0_base, b0_count, b1_base, b1_count;
  logic        b0_ready, b0_last, b0_finished, b0_empty;
  logic        b1_ready, b1_last, b1_finished, b1_empty;

  logic        ack_fire, finish_fire, flush_ok;
  logic        act_ready, act_last;
  logic [31:0] act_base, act_count;
  logic [23:0] blk_next;

  logic unused_bus_inputs;
  assign unused_bus_inputs = ^{i_mem_dat, i_mem_int};

  assign act_ready = active_q ? b1_ready : b0_ready;
  assign act_last  = active_q ? b1_last  : b0_last;
  assign act_base  = active_q ? b1_base  : b0_base;
  assign act_count = active_q ? b1_count : b0_count;
  assign blk_next  = blk_q + 24'd1;
  assign ack_fire  = (state_q == ST_WAIT_ACK) && bus_q && i_mem_ack;

  // Flushes wait for a gap between bus cycles so an in-flight write never lands in a closed buffer.
  assign flush_ok = (state_q == ST_IDLE) || (state_q == ST_ACTIVATE) ||
                    ((state_q == ST_WRITE) && !(i_enable && act_ready));

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    act_d        = act_q;
    bus_d        = bus_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    blk_d        = blk_q;
    wr_fin_d     = 1'b0;
    flush_pend_d = flush_pend_q | i_flush;
    finish_fire  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_enable && i_ppfifo_rdy && act_ready) state_d = ST_ACTIVATE;
      end
      ST_ACTIVATE: begin
        act_d   = 1'b1;
        blk_d   = 24'd0;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (!i_enable) begin
          act_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (act_ready) begin
          bus_d   = 1'b1;
          adr_d   = word_addr(act_base, act_count);
          dat_d   = i_ppfifo_data;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_fire) begin
          bus_d       = 1'b0;
          blk_d       = blk_next;
          finish_fire = act_last;
          if ((blk_next == i_ppfifo_size) || !i_enable) begin
            act_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        act_d   = 1'b0;
        bus_d   = 1'b0;
      end
    endcase

    if (flush_pend_q && flush_ok) begin
      flush_pend_d = i_flush;
      if (act_ready && (act_count != 32'd0)) finish_fire = 1'b1;
    end

    if (finish_fire) begin
      active_d = ~active_q;
      wr_fin_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      active_q     <= 1'b0;
      act_q        <= 1'b0;
      bus_q        <= 1'b0;
      adr_q        <= 32'd0;
      dat_q        <= 32'd0;
      blk_q        <= 24'd0;
      wr_fin_q     <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      act_q        <= act_d;
      bus_q        <= bus_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      blk_q        <= blk_d;
      wr_fin_q     <= wr_fin_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  p2m_buffer_ctrl u_buf0 (
    .clk        (clk),
    .rst        (rst),
    .arm_i      (i_memory_0_ready),
    .base_i     (i_memory_0_base),
    .size_i     (i_memory_0_size),
    .inc_i      (ack_fire & ~active_q),
    .finish_i   (finish_fire & ~active_q),
    .base_o     (b0_base),
    .count_o    (b0_count),
    .ready_o    (b0_ready),
    .last_o     (b0_last),
    .finished_o (b0_finished),
    .empty_o    (b0_empty)
  );

  p2m_buffer_ctrl u_buf1 (
    .clk        (clk),
    .rst        (rst),
    .arm_i      (i_memory_1_ready),
    .base_i     (i_memory_1_base),
    .size_i     (i_memory_1_size),
    .inc_i      (ack_fire & active_q),
    .finish_i   (finish_fire & active_q),
    .base_o     (b1_base),
    .count_o    (b1_count),
    .ready_o    (b1_ready),
    .last_o     (b1_last),
    .finished_o (b1_finished),
    .empty_o    (b1_empty)
  );

  assign o_memory_0_count     = b0_count;
  assign o_memory_0_finished  = b0_finished;
  assign o_memory_0_empty     = b0_empty;
  assign o_default_mem_0_base = DEFAULT_MEM_0_BASE;
  assign o_memory_1_count     = b1_count;
  assign o_memory_1_finished  = b1_finished;
  assign o_memory_1_empty     = b1_empty;
  assign o_default_mem_1_base = DEFAULT_MEM_1_BASE;

  assign o_write_finished = wr_fin_q;
  assign o_mem_cyc        = bus_q;
  assign o_mem_stb        = bus_q;
  assign o_mem_we         = bus_q;
  assign o_mem_sel        = {4{bus_q}};
  assign o_mem_adr        = adr_q;
  assign o_mem_dat        = dat_q;
  assign o_ppfifo_act     = act_q;
  // Combinational so the FIFO advances during the ack cycle and WRITE sees the next word.
  assign o_ppfifo_stb     = ack_fire;

`ifdef WB_PPFIFO_2_MEM_DEBUG_EN
  assign debug = {16'h0, b0_count[3:0], b1_count[3:0], act_q, bus_q, active_q,
                  b1_finished, b0_finished, state_q};
`else
  assign debug = 32'h0;
`endif

endmodule

// File: tb/tb_wb_ppfifo_2_mem.sv
// Randomized scoreboard bench for wb_ppfifo_2_mem with a queue-based buffer model.
module tb_wb_ppfifo_2_mem;

  logic        clk, rst;
  logic [31:0] debug;
  logic        i_enable, i_flush;
  logic [31:0] i_memory_0_base, i_memory_0_size, o_memory_0_count, o_default_mem_0_base;
  logic        i_memory_0_ready, o_memory_0_finished, o_memory_0_empty;
  logic [31:0] i_memory_1_base, i_memory_1_size, o_memory_1_count, o_default_mem_1_base;
  logic        i_memory_1_ready, o_memory_1_finished, o_memory_1_empty;
  logic        o_write_finished;
  logic        o_mem_we, o_mem_stb, o_mem_cyc;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_adr, o_mem_dat, i_mem_dat;
  logic        i_mem_ack, i_mem_int;
  logic        i_ppfifo_rdy, o_ppfifo_act, o_ppfifo_stb;
  logic [23:0] i_ppfifo_size;
  logic [31:0] i_ppfifo_data;

  wb_ppfifo_2_mem dut (
    .clk(clk), .rst(rst), .debug(debug), .i_enable(i_enable), .i_flush(i_flush),
    .i_memory_0_base(i_memory_0_base), .i_memory_0_size(i_memory_0_size),
    .o_memory_0_count(o_memory_0_count), .i_memory_0_ready(i_memory_0_ready),
    .o_memory_0_finished(o_memory_0_finished), .o_memory_0_empty(o_memory_0_empty),
    .o_default_mem_0_base(o_default_mem_0_base),
    .i_memory_1_base(i_memory_1_base), .i_memory_1_size(i_memory_1_size),
    .o_memory_1_count(o_memory_1_count), .i_memory_1_ready(i_memory_1_ready),
    .o_memory_1_finished(o_memory_1_finished), .o_memory_1_empty(o_memory_1_empty),
    .o_default_mem_1_base(o_default_mem_1_base),
    .o_write_finished(o_write_finished),
    .o_mem_we(o_mem_we), .o_mem_stb(o_mem_stb), .o_mem_cyc(o_mem_cyc), .o_mem_sel(o_mem_sel),
    .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat), .i_mem_dat(i_mem_dat),
    .i_mem_ack(i_mem_ack), .i_mem_int(i_mem_int),
    .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act), .i_ppfifo_size(i_ppfifo_size),
    .o_ppfifo_stb(o_ppfifo_stb), .i_ppfifo_data(i_ppfifo_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic [31:0] fifo_q[$];

  logic [31:0] m_base[2];
  logic [31:0] m_size[2];
  logic [31:0] m_count[2];
  bit          m_armed[2];
  bit          m_fin[2];
  int          m_active;
  int          exp_wfin;

  int wfin_seen = 0;
  int stb_seen  = 0;
  int ack_seen  = 0;
  int ack_delay = 0;
  bit ack_hold  = 1'b0;
  int wait_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wishbone slave with programmable ack latency; scoreboard compares every bus cycle.
  always @(negedge clk) begin
    if (rst) begin
      i_mem_ack = 1'b0;
      wait_cnt  = 0;
      exp_adr.delete();
      exp_dat.delete();
    end else if (i_mem_ack) begin
      i_mem_ack = 1'b0;
    end else if (o_mem_cyc && o_mem_stb && !ack_hold) begin
      if (exp_adr.size() == 0) begin
        check("unexpected_write", 32'(o_mem_cyc), 32'd0);
        i_mem_ack = 1'b1;
      end else begin
        check("bus_adr", o_mem_adr, exp_adr[0]);
        check("bus_dat", o_mem_dat, exp_dat[0]);
        if (wait_cnt >= ack_delay) begin
          check("bus_we_sel", {27'd0, o_mem_we, o_mem_sel}, 32'h1F);
          void'(exp_adr.pop_front());
          void'(exp_dat.pop_front());
          i_mem_ack = 1'b1;
          wait_cnt  = 0;
          ack_seen++;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // First-word-fall-through FIFO model plus pulse counters.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      fifo_q.delete();
    end else begin
      if (o_ppfifo_stb) begin
        stb_seen++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      if (o_write_finished) wfin_seen++;
    end
    i_ppfifo_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  end

  function automatic void model_word(input logic [31:0] w);
    exp_adr.push_back(m_base[m_active] + m_count[m_active]);
    exp_dat.push_back(w);
    m_count[m_active] = m_count[m_active] + 32'd1;
    if (m_count[m_active] == m_size[m_active]) begin
      m_fin[m_active] = 1'b1;
      exp_wfin++;
      m_active = 1 - m_active;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_ppfifo_rdy = 1'b0;
    i_flush = 1'b0;
    i_memory_0_ready = 1'b0;
    i_memory_1_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      m_armed[n] = 1'b0; m_fin[n] = 1'b0;
      m_count[n] = 32'd0; m_base[n] = 32'd0; m_size[n] = 32'd0;
    end
    m_active = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_wfin = wfin_seen;
  endtask

  task automatic arm(input int n, input logic [31:0] base, input logic [31:0] size);
    @(negedge clk);
    if (n == 0) begin
      i_memory_0_base = base; i_memory_0_size = size; i_memory_0_ready = 1'b1;
    end else begin
      i_memory_1_base = base; i_memory_1_size = size; i_memory_1_ready = 1'b1;
    end
    @(negedge clk);
    i_memory_0_ready = 1'b0;
    i_memory_1_ready = 1'b0;
    if (size != 32'd0) begin
      m_armed[n] = 1'b1; m_fin[n] = 1'b0;
      m_base[n] = base; m_size[n] = size; m_count[n] = 32'd0;
    end
  endtask

  task automatic send_block(input int len);
    int  t;
    int  falls;
    bit  prev;
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      model_word(w);
    end
    @(negedge clk);
    i_ppfifo_size = len[23:0];
    i_ppfifo_rdy  = 1'b1;
    t = 0;
    while (!o_ppfifo_act && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("block_act", 32'(o_ppfifo_act), 32'd1);
    i_ppfifo_rdy = 1'b0;
    falls = 0; prev = 1'b1; t = 0;
    while ((fifo_q.size() != 0 || o_ppfifo_act) && t < 1000) begin
      @(negedge clk);
      t++;
      if (prev && !o_ppfifo_act) falls++;
      prev = o_ppfifo_act;
    end
    check("block_drained", 32'(fifo_q.size()), 32'd0);
    check("act_single_release", 32'(falls), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    if (m_armed[m_active] && !m_fin[m_active] && m_count[m_active] != 32'd0) begin
      m_fin[m_active] = 1'b1;
      exp_wfin++;
      m_active = 1 - m_active;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_bufs(input string tag);
    check({tag, "_count0"}, o_memory_0_count, m_count[0]);
    check({tag, "_count1"}, o_memory_1_count, m_count[1]);
    check({tag, "_fin0"}, 32'(o_memory_0_finished), 32'(m_fin[0]));
    check({tag, "_fin1"}, 32'(o_memory_1_finished), 32'(m_fin[1]));
    check({tag, "_empty0"}, 32'(o_memory_0_empty), 32'(!m_armed[0] || m_fin[0]));
    check({tag, "_empty1"}, 32'(o_memory_1_empty), 32'(!m_armed[1] || m_fin[1]));
    check({tag, "_wfin_pulses"}, 32'(wfin_seen), 32'(exp_wfin));
  endtask

  initial begin
    int w0, s0, a0, t, cyc_cnt, cap, len;
    rst = 1'b1; i_enable = 1'b1; i_flush = 1'b0;
    i_memory_0_base = 32'd0; i_memory_0_size = 32'd0; i_memory_0_ready = 1'b0;
    i_memory_1_base = 32'd0; i_memory_1_size = 32'd0; i_memory_1_ready = 1'b0;
    i_mem_dat = 32'd0; i_mem_int = 1'b0;
    i_ppfifo_rdy = 1'b0; i_ppfifo_size = 24'd0;
    do_reset();

    check("rst_cyc", 32'(o_mem_cyc), 32'd0);
    check("rst_act", 32'(o_ppfifo_act), 32'd0);
    check("rst_wfin", 32'(o_write_finished), 32'd0);
    check("rst_debug", debug, 32'h0);
    check("default_base0", o_default_mem_0_base, 32'h0000_0000);
    check("default_base1", o_default_mem_1_base, 32'h0010_0000);
    check_bufs("rst");

    // Single buffer filled exactly by one block.
    w0 = wfin_seen;
    arm(0, 32'h100, 32'd4);
    send_block(4);
    check_bufs("t1");
    check("t1_one_pulse", 32'(wfin_seen - w0), 32'd1);

    // Block spills from buffer 0 into buffer 1 with act held.
    do_reset();
    arm(0, 32'h0, 32'd2);
    arm(1, 32'h200, 32'd4);
    send_block(4);
    check_bufs("t2");
    check("t2_count1", o_memory_1_count, 32'd2);

    // Partial buffer closed by flush; a later flush at count 0 is ignored.
    do_reset();
    arm(0, 32'h80, 32'd8);
    send_block(3);
    flush_pulse();
    check_bufs("t3a");
    check("t3a_count0", o_memory_0_count, 32'd3);
    arm(1, 32'h900, 32'd4);
    w0 = wfin_seen;
    flush_pulse();
    check_bufs("t3b");
    check("t3b_no_pulse", 32'(wfin_seen - w0), 32'd0);

    // Zero-size arm leaves the buffer empty and the bus idle.
    do_reset();
    arm(0, 32'h300, 32'd0);
    check("t4_empty0", 32'(o_memory_0_empty), 32'd1);
    fifo_q.push_back(32'hDEAD_0001);
    fifo_q.push_back(32'hDEAD_0002);
    i_ppfifo_size = 24'd2;
    i_ppfifo_rdy  = 1'b1;
    cyc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_mem_cyc || o_ppfifo_act) cyc_cnt++;
    end
    check("t4_no_bus", 32'(cyc_cnt), 32'd0);
    i_ppfifo_rdy = 1'b0;

    // Reset while a bus cycle waits for ack.
    do_reset();
    arm(0, 32'h40, 32'd4);
    ack_hold = 1'b1;
    fifo_q.push_back(32'h1234_5678);
    fifo_q.push_back(32'h9ABC_DEF0);
    i_ppfifo_size = 24'd2;
    i_ppfifo_rdy  = 1'b1;
    t = 0;
    while (!o_mem_cyc && t < 50) begin
      @(negedge clk);
      t++;
    end
    i_ppfifo_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_cyc_waiting", 32'(o_mem_cyc), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_cyc", 32'(o_mem_cyc), 32'd0);
    check("t5_stb", 32'(o_mem_stb), 32'd0);
    check("t5_act", 32'(o_ppfifo_act), 32'd0);
    check("t5_count0", o_memory_0_count, 32'd0);
    check("t5_empty0", 32'(o_memory_0_empty), 32'd1);
    rst = 1'b0;
    ack_hold = 1'b0;

    // Slow slave: five wait cycles per write.
    do_reset();
    ack_delay = 5;
    arm(0, 32'h500, 32'd8);
    s0 = stb_seen;
    a0 = ack_seen;
    send_block(3);
    check("t6_acks", 32'(ack_seen - a0), 32'd3);
    check("t6_fifo_stb", 32'(stb_seen - s0), 32'd3);
    check_bufs("t6");
    ack_delay = 0;

    // Random buffers, blocks and ack latencies.
    do_reset();
    for (int it = 0; it < 12; it++) begin
      for (int n = 0; n < 2; n++)
        if (!m_armed[n] || m_fin[n])
          arm(n, $urandom & 32'hFFFF_FFF0, 32'($urandom_range(1, 6)));
      ack_delay = int'($urandom_range(0, 3));
      cap = int'((m_size[0] - m_count[0]) + (m_size[1] - m_count[1]));
      len = int'($urandom_range(1, cap));
      send_block(len);
      check_bufs("rand");
    end

    check("scoreboard_drained", 32'(exp_adr.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
